// File: rtl/mcp3008_responder_if.sv
// mcp3008_responder_if: 4-wire SPI link between an MCP3008 initiator and
// the on-fabric responder. dout_oe travels with the bus so the top level can
// build the MISO tristate from it.
interface mcp3008_responder_if;
  logic cs_n;
  logic sclk;
  logic din;
  logic dout;
  logic dout_oe;

  // Initiator side: owns chip select, clock and command line
  modport master (
    output cs_n,
    output sclk,
    output din,
    input  dout,
    input  dout_oe
  );

  // Responder side: listens to the initiator and answers on dout
  modport slave (
    input  cs_n,
    input  sclk,
    input  din,
    output dout,
    output dout_oe
  );
endinterface

// File: rtl/mcp3008_responder.sv
// mcp3008_responder: device-side emulation of an MCP3008 ADC. All SPI pins
// are asynchronous to clk, so they are oversampled through synchronizers and
// the SPI edges are recovered from the synchronized sclk. Conversion results
// come from fabric-supplied channel words instead of a real converter.
module mcp3008_responder #(
  parameter int N    = 10,
  parameter int NCH  = 8,
  parameter int SYNC = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  mcp3008_responder_if.slave  spi,
  input  logic [NCH*N-1:0]    ch_data,
  output logic                cmd_valid,
  output logic                cmd_sgl,
  output logic [2:0]          cmd_ch,
  output logic [N-1:0]        sample_out,
  output logic                xfer_done,
  output logic                xfer_abort
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    CMD,
    SAMPLE,
    SHIFT,
    TAIL
  } state_t;

  state_t state, state_nxt;

  logic [1:0]      rst_pipe;
  logic            rst_n_int;

  logic [SYNC-1:0] cs_pipe;
  logic [SYNC-1:0] sclk_pipe;
  logic [SYNC-1:0] din_pipe;
  logic            cs_s, sclk_s, din_s;
  logic            cs_d, sclk_d;
  logic            cs_rise, cs_fall, sclk_rise, sclk_fall;

  logic [2:0]      cmd_sr, cmd_sr_nxt;
  logic [1:0]      cmd_cnt, cmd_cnt_nxt;
  logic [CW-1:0]   bit_cnt, bit_cnt_nxt;
  logic            last_sent, last_sent_nxt;
  logic            seen_r5, seen_r5_nxt;
  logic            dout_q, dout_nxt;
  logic            oe_q, oe_nxt;
  logic            cmd_valid_nxt, cmd_sgl_nxt;
  logic [2:0]      cmd_ch_nxt;
  logic [N-1:0]    sample_nxt;
  logic            done_nxt, abort_nxt;

  logic [N-1:0]    ch [NCH];
  logic [2:0]      sel_p, sel_m;
  logic [N:0]      diff;
  logic [N-1:0]    sample_calc;

  // Reset asserts immediately but releases only on a clk edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_pipe <= '0;
    else          rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign rst_n_int = rst_pipe[1];

  // Bring the asynchronous SPI pins into the clk domain; cs_n idles high
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      cs_pipe   <= '1;
      sclk_pipe <= '0;
      din_pipe  <= '0;
      cs_d      <= 1'b1;
      sclk_d    <= 1'b0;
    end else begin
      cs_pipe   <= {cs_pipe[SYNC-2:0], spi.cs_n};
      sclk_pipe <= {sclk_pipe[SYNC-2:0], spi.sclk};
      din_pipe  <= {din_pipe[SYNC-2:0], spi.din};
      cs_d      <= cs_pipe[SYNC-1];
      sclk_d    <= sclk_pipe[SYNC-1];
    end
  end

  assign cs_s      = cs_pipe[SYNC-1];
  assign sclk_s    = sclk_pipe[SYNC-1];
  assign din_s     = din_pipe[SYNC-1];
  assign cs_rise   =  cs_s   & ~cs_d;
  assign cs_fall   = ~cs_s   &  cs_d;
  assign sclk_rise =  sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s &  sclk_d;

  for (genvar g = 0; g < NCH; g++) begin : g_unpack
    assign ch[g] = ch_data[g*N +: N];
  end

  // Conversion result for the command completing at R4; D0 is still on din_s
  always_comb begin
    sel_p       = {cmd_sr[1:0], din_s};
    sel_m       = {cmd_sr[1:0], ~din_s};
    diff        = {1'b0, ch[sel_p]} - {1'b0, ch[sel_m]};
    sample_calc = '0;
    if (cmd_sr[2])     sample_calc = ch[sel_p];
    else if (!diff[N]) sample_calc = diff[N-1:0];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next state and next register values; a cs_n rise overrides any sclk edge
  always_comb begin
    state_nxt     = state;
    cmd_sr_nxt    = cmd_sr;
    cmd_cnt_nxt   = cmd_cnt;
    bit_cnt_nxt   = bit_cnt;
    last_sent_nxt = last_sent;
    seen_r5_nxt   = seen_r5;
    dout_nxt      = dout_q;
    oe_nxt        = oe_q;
    cmd_valid_nxt = 1'b0;
    cmd_sgl_nxt   = cmd_sgl;
    cmd_ch_nxt    = cmd_ch;
    sample_nxt    = sample_out;
    done_nxt      = 1'b0;
    abort_nxt     = 1'b0;

    if (cs_rise) begin
      state_nxt = IDLE;
      dout_nxt  = 1'b0;
      oe_nxt    = 1'b0;
      done_nxt  = (state == TAIL);
      abort_nxt = (state == CMD) || (state == SAMPLE) || (state == SHIFT);
    end else begin
      unique case (state)
        IDLE: begin
          if (cs_fall) state_nxt = START;
        end
        START: begin
          if (sclk_rise && din_s) begin
            state_nxt   = CMD;
            cmd_sr_nxt  = '0;
            cmd_cnt_nxt = '0;
          end
        end
        CMD: begin
          if (sclk_rise) begin
            cmd_sr_nxt  = {cmd_sr[1:0], din_s};
            cmd_cnt_nxt = cmd_cnt + 2'd1;
            if (cmd_cnt == 2'd3) begin
              cmd_sgl_nxt   = cmd_sr[2];
              cmd_ch_nxt    = {cmd_sr[1:0], din_s};
              sample_nxt    = sample_calc;
              cmd_valid_nxt = 1'b1;
              oe_nxt        = 1'b1;
              dout_nxt      = 1'b0;
              seen_r5_nxt   = 1'b0;
              state_nxt     = SAMPLE;
            end
          end
        end
        SAMPLE: begin
          if (sclk_rise) begin
            seen_r5_nxt = 1'b1;
          end else if (sclk_fall && seen_r5) begin
            dout_nxt      = 1'b0;
            bit_cnt_nxt   = CW'(N - 1);
            last_sent_nxt = 1'b0;
            state_nxt     = SHIFT;
          end
        end
        SHIFT: begin
          if (sclk_fall && !last_sent) begin
            dout_nxt = sample_out[bit_cnt];
            if (bit_cnt == '0) last_sent_nxt = 1'b1;
            else               bit_cnt_nxt   = bit_cnt - CW'(1);
          end else if (sclk_rise && last_sent) begin
            dout_nxt  = 1'b0;
            state_nxt = TAIL;
          end
        end
        TAIL: begin
          dout_nxt = 1'b0;
        end
        default: begin
          state_nxt = IDLE;
          dout_nxt  = 1'b0;
          oe_nxt    = 1'b0;
        end
      endcase
    end
  end

  // Datapath and output registers following the FSM decisions
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      cmd_sr     <= '0;
      cmd_cnt    <= '0;
      bit_cnt    <= '0;
      last_sent  <= 1'b0;
      seen_r5    <= 1'b0;
      dout_q     <= 1'b0;
      oe_q       <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_sgl    <= 1'b0;
      cmd_ch     <= '0;
      sample_out <= '0;
      xfer_done  <= 1'b0;
      xfer_abort <= 1'b0;
    end else begin
      cmd_sr     <= cmd_sr_nxt;
      cmd_cnt    <= cmd_cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      last_sent  <= last_sent_nxt;
      seen_r5    <= seen_r5_nxt;
      dout_q     <= dout_nxt;
      oe_q       <= oe_nxt;
      cmd_valid  <= cmd_valid_nxt;
      cmd_sgl    <= cmd_sgl_nxt;
      cmd_ch     <= cmd_ch_nxt;
      sample_out <= sample_nxt;
      xfer_done  <= done_nxt;
      xfer_abort <= abort_nxt;
    end
  end

  assign spi.dout    = dout_q;
  assign spi.dout_oe = oe_q;

endmodule
